wb_drain: RTL and testbench

WB_DRAIN -- requirements
Module: wb_drain

---
 rtl/wb_drain.sv | 122 ++++++++++++
 tb/tb_wb_drain.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_drain.sv
// Writeback drain queue: buffers register-file writes in a small FIFO, drains one per unstalled cycle.
// Optional pending-write lookup (bypass) compiled in with `define WB_BYPASS_EN.
module wb_drain #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [4:0]  in_reg,
    input  logic [31:0] in_data,
    output logic        in_ready,
    input  logic        wb_stall,
    output logic        regWrite,
    output logic [4:0]  writeReg,
    output logic [31:0] writeData,
    input  logic [4:0]  lookupReg1,
    input  logic [4:0]  lookupReg2,
    output logic        hit1,
    output logic        hit2,
    output logic [31:0] hitData1,
    output logic [31:0] hitData2
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [4:0]       reg_mem_q  [DEPTH];
    logic [31:0]      data_mem_q [DEPTH];
    logic             not_empty_s;
    logic             enq_s;
    logic             deq_s;

    assign not_empty_s = (count_q != CNT_W'(0));
    assign in_ready    = (count_q < CNT_W'(DEPTH));
    // Register 0 requests complete the handshake but never occupy a slot.
    assign enq_s       = in_valid && in_ready && (in_reg != 5'd0);
    assign deq_s       = regWrite;
    assign regWrite    = not_empty_s && !wb_stall;
    assign writeReg    = not_empty_s ? reg_mem_q[head_q]  : 5'd0;
    assign writeData   = not_empty_s ? data_mem_q[head_q] : 32'h0000_0000;

    // Next-state for pointers and occupancy count.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (enq_s) begin
            tail_d = tail_q + PTR_W'(1);
        end else begin
            tail_d = tail_q;
        end
        if (deq_s) begin
            head_d = head_q + PTR_W'(1);
        end else begin
            head_d = head_q;
        end
        case ({enq_s, deq_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count state; reset discards every pending entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage is left uncleared; validity comes from the count alone.
    always_ff @(posedge clk) begin
        if (enq_s) begin
            reg_mem_q[tail_q]  <= in_reg;
            data_mem_q[tail_q] <= in_data;
        end
    end

`ifdef WB_BYPASS_EN
    // Scan oldest to youngest so the youngest match wins; result is {hit, data}.
    function automatic logic [32:0] bypass_lookup(input logic [4:0] addr);
        logic [32:0]      result;
        logic [PTR_W-1:0] idx;
        logic             match;
        result = 33'h0_0000_0000;
        for (int i = 0; i < DEPTH; i++) begin
            idx    = head_q + PTR_W'(i);
            match  = (CNT_W'(i) < count_q) && (reg_mem_q[idx] == addr) && (addr != 5'd0);
            result = match ? {1'b1, data_mem_q[idx]} : result;
        end
        return result;
    endfunction

    logic [32:0] look1_s;
    logic [32:0] look2_s;

    assign look1_s  = bypass_lookup(lookupReg1);
    assign look2_s  = bypass_lookup(lookupReg2);
    assign hit1     = look1_s[32];
    assign hitData1 = look1_s[31:0];
    assign hit2     = look2_s[32];
    assign hitData2 = look2_s[31:0];
`else
    logic lookup_unused_s;

    assign lookup_unused_s = ^{lookupReg1, lookupReg2};
    assign hit1     = 1'b0;
    assign hit2     = 1'b0;
    assign hitData1 = 32'h0000_0000;
    assign hitData2 = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_wb_drain.sv
// Directed self-checking bench for wb_drain (DEPTH = 4); bypass expectations follow WB_BYPASS_EN.
module tb_wb_drain;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [4:0]  in_reg;
    logic [31:0] in_data;
    logic        in_ready;
    logic        wb_stall;
    logic        regWrite;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic [4:0]  lookupReg1;
    logic [4:0]  lookupReg2;
    logic        hit1;
    logic        hit2;
    logic [31:0] hitData1;
    logic [31:0] hitData2;

    int errors = 0;
    int checks = 0;

    wb_drain #(.DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_reg     (in_reg),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .wb_stall   (wb_stall),
        .regWrite   (regWrite),
        .writeReg   (writeReg),
        .writeData  (writeData),
        .lookupReg1 (lookupReg1),
        .lookupReg2 (lookupReg2),
        .hit1       (hit1),
        .hit2       (hit2),
        .hitData1   (hitData1),
        .hitData2   (hitData2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_hit(input string tag, input logic h, input logic [31:0] d,
                           input logic exp_h, input logic [31:0] exp_d);
`ifdef WB_BYPASS_EN
        chk({tag, "_hit"},  {31'd0, h}, {31'd0, exp_h});
        chk({tag, "_data"}, d, exp_d);
`else
        chk({tag, "_hit"},  {31'd0, h}, 32'd0);
        chk({tag, "_data"}, d, 32'd0);
        if (exp_h === 1'bx) $display("unreachable %h", exp_d);
`endif
    endtask

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_reg     = 5'd0;
        in_data    = 32'h0;
        wb_stall   = 1'b0;
        lookupReg1 = 5'd0;
        lookupReg2 = 5'd0;
        #1;
        chk("rst_regWrite", {31'd0, regWrite}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_hit1",     {31'd0, hit1},     32'd0);
        chk("rst_hitData1", hitData1,          32'd0);
        step();
        reset = 1'b0;
        step();

        // Single push, drains the following cycle with no fall-through.
        in_valid = 1'b1; in_reg = 5'd3; in_data = 32'hA5A5_A5A5;
        #1;
        chk("p1_in_ready",  {31'd0, in_ready}, 32'd1);
        chk("p1_nofall",    {31'd0, regWrite}, 32'd0);
        step();
        in_valid = 1'b0; in_reg = 5'd0; in_data = 32'h0;
        #1;
        chk("p1_regWrite",  {31'd0, regWrite}, 32'd1);
        chk("p1_writeReg",  {27'd0, writeReg}, 32'd3);
        chk("p1_writeData", writeData,         32'hA5A5_A5A5);
        step();
        chk("p1_done",      {31'd0, regWrite}, 32'd0);

        // Fill under stall, fifth request held off, then drain in order with wrap.
        wb_stall = 1'b1;
        for (int r = 1; r <= 5; r++) begin
            in_valid = 1'b1; in_reg = 5'(r); in_data = 32'h100 + 32'(r);
            #1;
            chk($sformatf("fill_ready_%0d", r), {31'd0, in_ready}, (r <= 4) ? 32'd1 : 32'd0);
            chk($sformatf("fill_stall_%0d", r), {31'd0, regWrite}, 32'd0);
            if (r <= 4) step();
        end
        lookupReg1 = 5'd2; lookupReg2 = 5'd5;
        #1;
        chk_hit("full_l1", hit1, hitData1, 1'b1, 32'h102);
        chk_hit("full_l2", hit2, hitData2, 1'b0, 32'h0);
        wb_stall = 1'b0; lookupReg1 = 5'd1; lookupReg2 = 5'd0;
        #1;
        chk_hit("drain_head", hit1, hitData1, 1'b1, 32'h101);
        for (int k = 1; k <= 5; k++) begin
            chk($sformatf("drain_we_%0d", k),   {31'd0, regWrite}, 32'd1);
            chk($sformatf("drain_reg_%0d", k),  {27'd0, writeReg}, 32'(k));
            chk($sformatf("drain_data_%0d", k), writeData,         32'h100 + 32'(k));
            if (k == 1) chk("drain_full_ready", {31'd0, in_ready}, 32'd0);
            if (k == 2) chk("drain_acc_ready",  {31'd0, in_ready}, 32'd1);
            step();
            if (k == 2) begin
                in_valid = 1'b0; in_reg = 5'd0; in_data = 32'h0;
                #1;
            end
        end
        chk("drain_empty", {31'd0, regWrite}, 32'd0);
        lookupReg1 = 5'd0;

        // Register 0 request is accepted but never written.
        in_valid = 1'b1; in_reg = 5'd0; in_data = 32'hFFFF_FFFF;
        #1;
        chk("r0_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0; in_data = 32'h0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("r0_nowrite_%0d", c), {31'd0, regWrite}, 32'd0);
            step();
        end

        // Youngest matching entry wins; lookup of register 0 never hits.
        wb_stall = 1'b1;
        in_valid = 1'b1; in_reg = 5'd7; in_data = 32'h11;
        step();
        in_data = 32'h22; lookupReg1 = 5'd7;
        #1;
        chk_hit("byp_same_cycle", hit1, hitData1, 1'b1, 32'h11);
        step();
        in_valid = 1'b0; in_reg = 5'd0; in_data = 32'h0;
        #1;
        chk_hit("byp_l1", hit1, hitData1, 1'b1, 32'h22);
        chk_hit("byp_l2", hit2, hitData2, 1'b0, 32'h0);
        lookupReg2 = 5'd7;
        #1;
        chk_hit("byp_l2_7", hit2, hitData2, 1'b1, 32'h22);
        lookupReg2 = 5'd0;

        // Third entry, then asynchronous reset discards everything.
        in_valid = 1'b1; in_reg = 5'd9; in_data = 32'h33;
        step();
        in_valid = 1'b0; in_reg = 5'd0; in_data = 32'h0;
        #1;
        chk("pre_rst_stall", {31'd0, regWrite}, 32'd0);
        reset = 1'b1;
        #1;
        chk("arst_ready",    {31'd0, in_ready}, 32'd1);
        chk_hit("arst_l1", hit1, hitData1, 1'b0, 32'h0);
        step();
        reset = 1'b0; wb_stall = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk($sformatf("post_rst_we_%0d", c), {31'd0, regWrite}, 32'd0);
            chk($sformatf("post_rst_ready_%0d", c), {31'd0, in_ready}, 32'd1);
            step();
        end

        // Normal operation after reset, including a simultaneous accept and drain.
        lookupReg1 = 5'd0;
        in_valid = 1'b1; in_reg = 5'd12; in_data = 32'hC0C0;
        step();
        in_reg = 5'd13; in_data = 32'hD0D0;
        #1;
        chk("post_we_a",   {31'd0, regWrite}, 32'd1);
        chk("post_reg_a",  {27'd0, writeReg}, 32'd12);
        chk("post_data_a", writeData,         32'hC0C0);
        step();
        in_valid = 1'b0; in_reg = 5'd0; in_data = 32'h0;
        #1;
        chk("post_we_b",   {31'd0, regWrite}, 32'd1);
        chk("post_reg_b",  {27'd0, writeReg}, 32'd13);
        chk("post_data_b", writeData,         32'hD0D0);
        step();
        chk("post_empty",  {31'd0, regWrite}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
